// File: rtl/icache_refill.sv
// Instruction-cache refill controller.
// On a fetch miss it latches the line address and issues one line read to memory.
// The returned 64-bit beats are streamed into the icache write port.
// A one-cycle refill_done pulse then tells the tag store to update.
module icache_refill #(
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss,
  input  logic [31:0] miss_pc,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [63:0] mem_data,
  output logic        fill,
  output logic [4:0]  fill_idx,
  output logic [63:0] stream,
  output logic        refill_done,
  output logic [31:0] refill_addr
);

  // Byte offset bits within a line, and beat counter width.
  localparam int unsigned OFF = $clog2(8 * LINE_BEATS);
  localparam int unsigned BW  = $clog2(LINE_BEATS);

  localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StStream,
    StDone
  } state_e;

  state_e        r_state;
  logic [BW-1:0] r_beat;
  logic [31:0]   r_line_addr;
  logic          r_mem_req;
  logic          r_fill;
  logic [4:0]    r_fill_idx;
  logic [63:0]   r_stream;
  logic          r_done;

  logic [31:0]   w_line_addr;
  logic [4:0]    w_idx;

  assign w_line_addr = miss_pc & LINE_MASK;
  // Word index inside the icache: line's word base plus the beat offset, wrapping in 5 bits.
  assign w_idx       = r_line_addr[7:3] + 5'(r_beat);

  // Refill sequencer: all outputs except stall are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_line_addr <= '0;
      r_mem_req   <= 1'b0;
      r_fill      <= 1'b0;
      r_fill_idx  <= '0;
      r_stream    <= '0;
      r_done      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_fill <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (miss) begin
            r_line_addr <= w_line_addr;
            r_mem_req   <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_beat    <= '0;
            r_state   <= StStream;
          end
        end
        StStream: begin
          if (mem_valid) begin
            r_stream   <= mem_data;
            r_fill_idx <= w_idx;
            r_fill     <= 1'b1;
            // Wraps to 0 on the last beat; the counter is reloaded before next use.
            r_beat     <= r_beat + BW'(1);
            if (r_beat == LAST_BEAT) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Fetch freezes in the same cycle the miss appears, before the FSM leaves idle.
  assign stall       = (r_state != StIdle) | miss;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_line_addr;
  assign refill_addr = r_line_addr;
  assign fill        = r_fill;
  assign fill_idx    = r_fill_idx;
  assign stream      = r_stream;
  assign refill_done = r_done;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus randomized refills
// checked cycle by cycle against a line/beat arithmetic model.
module tb_icache_refill;

  localparam int unsigned LB = 4;

  logic        clk;
  logic        rst_n;
  logic        miss;
  logic [31:0] miss_pc;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_valid;
  logic [63:0] mem_data;
  logic        fill;
  logic [4:0]  fill_idx;
  logic [63:0] stream;
  logic        refill_done;
  logic [31:0] refill_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fills = 0;
  int exp_done  = 0;
  int obs_fills = 0;
  int obs_done  = 0;

  icache_refill #(
    .LINE_BEATS(LB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss       (miss),
    .miss_pc    (miss_pc),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .fill       (fill),
    .fill_idx   (fill_idx),
    .stream     (stream),
    .refill_done(refill_done),
    .refill_addr(refill_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent tallies of write strobes and completion pulses.
  always @(negedge clk) begin
    if (fill) obs_fills <= obs_fills + 1;
    if (refill_done) obs_done <= obs_done + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full refill. Entered at posedge+1 of the cycle where the miss is presented,
  // with the DUT idle. Returns at posedge+1 of the next cycle in which a miss may be presented.
  task automatic refill(input logic [31:0] pc, input int ackd, input int gmin, input int gmax,
                        input bit chain);
    logic [31:0] base;
    logic [63:0] d;
    logic [63:0] pd;
    logic [4:0]  pidx;
    bit          pf;
    int          g;
    base = pc & ~(32'(8 * LB) - 32'd1);
    pd   = '0;
    pidx = '0;
    pf   = 1'b0;
    // Miss cycle
    miss      = 1'b1;
    miss_pc   = pc;
    mem_ack   = 1'($urandom);
    mem_valid = 1'($urandom);
    mem_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("miss_stall", 64'(stall), 64'd1);
    chk("idle_fill", 64'(fill), 64'd0);
    chk("idle_req", 64'(mem_req), 64'd0);
    step();
    // Request phase; miss is not sampled here, so scramble it.
    for (int i = 0; i < ackd; i++) begin
      miss      = 1'($urandom);
      miss_pc   = $urandom;
      mem_ack   = 1'b0;
      mem_valid = 1'($urandom);
      mem_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("req_hold", 64'(mem_req), 64'd1);
      chk("req_addr", 64'(mem_addr), 64'(base));
      chk("req_stall", 64'(stall), 64'd1);
      chk("req_fill", 64'(fill), 64'd0);
      step();
    end
    miss      = 1'($urandom);
    mem_ack   = 1'b1;
    mem_valid = 1'($urandom);
    mem_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("ack_req", 64'(mem_req), 64'd1);
    chk("ack_addr", 64'(mem_addr), 64'(base));
    chk("ack_fill", 64'(fill), 64'd0);
    step();
    // Stream phase
    for (int k = 0; k < int'(LB); k++) begin
      g = int'($urandom_range(gmax, gmin));
      for (int j = 0; j < g; j++) begin
        miss      = 1'($urandom);
        mem_ack   = 1'($urandom);
        mem_valid = 1'b0;
        mem_data  = {$urandom, $urandom};
        @(negedge clk);
        chk("gap_fill", 64'(fill), 64'(pf));
        if (pf) begin
          chk("gap_idx", 64'(fill_idx), 64'(pidx));
          chk("gap_data", stream, pd);
        end
        chk("gap_req", 64'(mem_req), 64'd0);
        chk("gap_stall", 64'(stall), 64'd1);
        chk("gap_done", 64'(refill_done), 64'd0);
        pf = 1'b0;
        step();
      end
      d         = {$urandom, $urandom};
      miss      = 1'($urandom);
      mem_ack   = 1'($urandom);
      mem_valid = 1'b1;
      mem_data  = d;
      @(negedge clk);
      chk("beat_fill", 64'(fill), 64'(pf));
      if (pf) begin
        chk("beat_idx", 64'(fill_idx), 64'(pidx));
        chk("beat_data", stream, pd);
      end
      chk("beat_stall", 64'(stall), 64'd1);
      chk("beat_done", 64'(refill_done), 64'd0);
      pf   = 1'b1;
      pidx = 5'((base >> 3) + 32'(k));
      pd   = d;
      exp_fills++;
      step();
    end
    // Done cycle: last fill coincides with the completion pulse.
    miss      = chain;
    mem_ack   = 1'($urandom);
    mem_valid = 1'($urandom);
    mem_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("done_fill", 64'(fill), 64'd1);
    chk("done_idx", 64'(fill_idx), 64'(pidx));
    chk("done_data", stream, pd);
    chk("done_pulse", 64'(refill_done), 64'd1);
    chk("done_addr", 64'(refill_addr), 64'(base));
    chk("done_stall", 64'(stall), 64'd1);
    chk("done_req", 64'(mem_req), 64'd0);
    exp_done++;
    step();
    if (!chain) begin
      miss      = 1'b0;
      mem_ack   = 1'($urandom);
      mem_valid = 1'($urandom);
      @(negedge clk);
      chk("resume_stall", 64'(stall), 64'd0);
      chk("resume_fill", 64'(fill), 64'd0);
      chk("resume_done", 64'(refill_done), 64'd0);
      chk("resume_addr", 64'(refill_addr), 64'(base));
      step();
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] base;
    logic [63:0] d0;
    logic [63:0] d1;
    rst_n     = 1'b0;
    miss      = 1'b0;
    miss_pc   = '0;
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;

    // Reset with random inputs: registered outputs cleared, stall follows miss.
    for (int i = 0; i < 4; i++) begin
      step();
      miss      = 1'($urandom);
      miss_pc   = $urandom;
      mem_ack   = 1'($urandom);
      mem_valid = 1'($urandom);
      mem_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_idx", 64'(fill_idx), 64'd0);
      chk("rst_stream", stream, 64'd0);
      chk("rst_done", 64'(refill_done), 64'd0);
      chk("rst_raddr", 64'(refill_addr), 64'd0);
      chk("rst_stall", 64'(stall), 64'(miss));
    end
    step();
    miss      = 1'b0;
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall), 64'd0);
    step();

    // Basic refill: minimum penalty, line 0x1220, indices 4..7.
    refill(32'h0000_1234, 0, 0, 0, 1'b0);
    chk("basic_line", 64'(refill_addr), 64'h0000_1220);

    // Backpressure: ack after 3 waiting cycles, one idle cycle before each beat.
    refill(32'h8000_0F48, 3, 1, 1, 1'b0);

    // Consecutive misses with no stall gap; second line indices 28..31.
    refill($urandom, 1, 0, 1, 1'b1);
    refill(32'h0000_00E0, 0, 0, 0, 1'b0);

    // Reset mid-refill after two beats.
    pc   = $urandom;
    base = pc & ~(32'(8 * LB) - 32'd1);
    d0   = {$urandom, $urandom};
    d1   = {$urandom, $urandom};
    miss    = 1'b1;
    miss_pc = pc;
    step();
    miss    = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_valid = 1'b1;
    mem_data  = d0;
    step();
    mem_data = d1;
    step();
    mem_valid = 1'b0;
    exp_fills += 2;
    @(negedge clk);
    chk("mid_fill", 64'(fill), 64'd1);
    chk("mid_idx", 64'(fill_idx), 64'(5'((base >> 3) + 32'd1)));
    chk("mid_data", stream, d1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_fill", 64'(fill), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_raddr", 64'(refill_addr), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = (i < 2);
      mem_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("after_rst_fill", 64'(fill), 64'd0);
      chk("after_rst_done", 64'(refill_done), 64'd0);
      chk("after_rst_req", 64'(mem_req), 64'd0);
      chk("after_rst_stall", 64'(stall), 64'd0);
      step();
    end
    mem_valid = 1'b0;

    // Randomized refills against the arithmetic model.
    for (int n = 0; n < 20; n++) begin
      refill($urandom, int'($urandom_range(3, 0)), 0, 2, 1'($urandom));
    end
    // The last random refill may have been chained; finish with a plain one.
    refill($urandom, 0, 0, 1, 1'b0);

    repeat (2) step();
    chk("fill_total", 64'(obs_fills), 64'(exp_fills));
    chk("done_total", 64'(obs_done), 64'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Instruction-cache refill controller sitting directly upstream of the fetch stage. When fetch reports a miss, this block holds the PC, requests the missing line from memory, and streams the returned 64-bit beats into the icache through the `fill` / `fill_idx` / `stream` write port. It then signals completion so the tag store can be updated and fetch can resume.

## Interface
- `LINE_BEATS`, default 4: 64-bit beats per cache line; power of two, 2..32.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss`  in  1  icache miss flag from fetch (combinational from current PC).
- `miss_pc`  in  32  PC that missed.
- `stall`  out  1  hold PC; fetch's `pc_write` = !stall.
- `mem_req`  out  1  line read request to memory.
- `mem_addr`  out  32  line-aligned byte address of the request.
- `mem_ack`  in  1  memory accepted the request.
- `mem_valid`  in  1  one data beat present on `mem_data`.
- `mem_data`  in  64  data beat, ascending address order.
- `fill`  out  1  icache write strobe.
- `fill_idx`  out  5  icache word index being written.
- `stream`  out  64  icache write data.
- `refill_done`  out  1  one-cycle pulse when the last beat is written.
- `refill_addr`  out  32  line address of the current/last refill, used as the tag-update address.

## Operation
- Line size is `8*LINE_BEATS` bytes, with `OFF = log2(8*LINE_BEATS)`.
- `line_addr` = `miss_pc` with bits `[OFF-1:0]` cleared. It is latched on miss acceptance and drives both `mem_addr` and `refill_addr`.
- `fill_idx` = `line_addr[7:3] + beat`, where `beat` counts 0..`LINE_BEATS`-1.
- FSM states: IDLE, REQ, STREAM, DONE.
  - IDLE: if `miss`=1, latch `line_addr` and go to REQ. Otherwise stay.
  - REQ: `mem_req`=1. When `mem_ack`=1, clear `beat` and go to STREAM.
  - STREAM: each cycle with `mem_valid`=1, register `mem_data` into `stream` and the current index into `fill_idx`, set `fill`=1 for the next cycle, and increment `beat`. When the beat with `beat`=`LINE_BEATS`-1 is accepted, go to DONE.
  - DONE: `refill_done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `stall` = (state != IDLE) | `miss` (combinational). Fetch is frozen from the cycle the miss appears.
- `mem_ack` outside REQ is ignored. `mem_valid` outside STREAM is ignored (no fill).
- `miss` is not sampled in REQ, STREAM or DONE. It is re-evaluated in the first IDLE cycle; a persisting miss starts a new refill.
- `beat` counter width is log2(`LINE_BEATS`). The final increment wraps to 0 and is harmless.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `beat`=0, `line_addr`=0.
  - Outputs: `mem_req`=0, `mem_addr`=0, `fill`=0, `fill_idx`=0, `stream`=0, `refill_done`=0, `refill_addr`=0.
  - `stall` = `miss` only.
- Reset mid-refill aborts immediately. No further `fill` is issued, and memory beats arriving after reset release are ignored.
- `fill`, `fill_idx`, `stream` and `refill_done` are registered outputs.
  - Each `fill` appears one cycle after its `mem_valid`.
  - The last `fill` coincides with `refill_done` (the DONE cycle).
- Minimum miss penalty, measured from the miss in cycle 0:
  - Cycle 0: `miss`=1, transition to REQ.
  - Cycle 1: REQ with `mem_ack`=1.
  - Cycles 2..5: STREAM, one `mem_valid` per cycle.
  - Cycles 3..6: `fill` pulses.
  - Cycle 6: DONE.
  - Cycle 7: IDLE, `stall`=0 if `miss`=0.
  - For `LINE_BEATS`=4, this is 7 stalled cycles.
- Gaps in `mem_valid` extend STREAM with no fill and no `beat` change.
- `mem_req` stays high through any number of non-ack cycles.

## Test plan
- Reset value: assert `rst_n`=0 with random inputs.
  - Required: all registered outputs 0; `stall` follows `miss`.
- Basic refill, `miss_pc`=0x0000_1234, `LINE_BEATS`=4, ack in the first REQ cycle, back-to-back beats D0..D3.
  - Required: `mem_addr`=0x0000_1220.
  - `fill` pulses on cycles 3..6 with `fill_idx`=4,5,6,7 and `stream`=D0..D3.
  - `refill_done` on cycle 6 with `refill_addr`=0x0000_1220; `stall` low on cycle 7.
- Memory backpressure: `mem_ack` delayed 3 cycles, one idle cycle between each beat.
  - Required: exactly 4 fills with the correct indices.
  - `mem_req` held until ack; `stall` high throughout.
- Spurious inputs: `mem_valid`=1 in IDLE and REQ, `mem_ack`=1 in STREAM.
  - Required: no `fill` and no state change from them.
- Reset mid-refill: `rst_n`=0 after beat 2, release, then two more `mem_valid` pulses.
  - Required: no fill after reset and no `refill_done`; state IDLE.
- Consecutive misses: `miss` still high in the IDLE cycle after DONE with `miss_pc`=0x0000_00E0.
  - Required: a new REQ with `mem_addr`=0x0000_00E0 and `fill_idx`=28..31; `stall` has no low gap.
